// File: rtl/opr_demux_buffered_if.sv
// Operand bus between decode (master) and the buffered operand demux (slave).
// Signals:
//   io_flush        master->slave  synchronous clear of every channel FIFO
//   io_in_valid     master->slave  operand request
//   io_in_ready     slave->master  operand taken when valid && ready
//   io_operand      master->slave  operand data
//   io_OPR_sel      master->slave  target channel, broadcast code or invalid
//   io_out_valid    slave->master  per-channel head valid
//   io_out_ready    master->slave  per-channel consumer ready
//   io_out_operand  slave->master  channel c at bits [c*WIDTH +: WIDTH]
//   io_drop_count   slave->master  saturating count of absorbed invalid selects
interface opr_demux_buffered_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 3,
  parameter int CNT_W    = 8
);
  logic                      io_flush;
  logic                      io_in_valid;
  logic                      io_in_ready;
  logic [WIDTH-1:0]          io_operand;
  logic [SEL_W-1:0]          io_OPR_sel;
  logic [CHANNELS-1:0]       io_out_valid;
  logic [CHANNELS-1:0]       io_out_ready;
  logic [CHANNELS*WIDTH-1:0] io_out_operand;
  logic [CNT_W-1:0]          io_drop_count;

  modport master (
    output io_flush, io_in_valid, io_operand, io_OPR_sel, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_operand, io_drop_count
  );

  modport slave (
    input  io_flush, io_in_valid, io_operand, io_OPR_sel, io_out_ready,
    output io_in_ready, io_out_valid, io_out_operand, io_drop_count
  );
endinterface

// File: rtl/opr_demux_buffered.sv
// Buffered operand demultiplexer.
// Steers one operand per accepted request into one of CHANNELS per-channel
// FIFOs (DEPTH entries each), or into all of them on the broadcast select
// (all ones). Any other out-of-range select is accepted, discarded and
// counted in a saturating drop counter.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    opr_demux_buffered_if.slave (handshake, data, flush, drop count)
// Channel state lives in its occupancy count: 0 = empty, DEPTH = full.
// io_in_ready looks only at select, flush and registered occupancy, so a
// pop in the same cycle never frees room for a push.
module opr_demux_buffered #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 3,
  parameter int DEPTH    = 2,
  parameter int CNT_W    = 8
) (
  input logic                 clock,
  input logic                 reset,
  opr_demux_buffered_if.slave bus
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam logic [SEL_W-1:0] BCAST_SEL = '1;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_q   [CHANNELS][DEPTH];
  logic [PTR_W-1:0] rd_ptr_q[CHANNELS];
  logic [PTR_W-1:0] wr_ptr_q[CHANNELS];
  logic [OCC_W-1:0] occ_q   [CHANNELS];
  logic [CNT_W-1:0] drop_q;

  logic                      sel_uni;
  logic                      sel_bcast;
  logic                      sel_full;
  logic                      in_ready;
  logic                      accept;
  logic [CHANNELS-1:0]       full;
  logic [CHANNELS-1:0]       not_empty;
  logic [CHANNELS-1:0]       push;
  logic [CHANNELS-1:0]       pop;
  logic [CHANNELS*WIDTH-1:0] out_operand;

  assign sel_uni   = bus.io_OPR_sel < SEL_W'(CHANNELS);
  assign sel_bcast = bus.io_OPR_sel == BCAST_SEL;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    full        = '0;
    not_empty   = '0;
    sel_full    = 1'b0;
    out_operand = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      full[c]      = occ_q[c] == OCC_FULL;
      not_empty[c] = occ_q[c] != '0;
      if (bus.io_OPR_sel == SEL_W'(c)) sel_full = full[c];
      // Empty channels read as zero rather than stale storage.
      if (not_empty[c]) out_operand[c*WIDTH +: WIDTH] = mem_q[c][rd_ptr_q[c]];
    end
  end

  always_comb begin
    in_ready = 1'b1;                    // invalid selects are always absorbed
    if (bus.io_flush)   in_ready = 1'b0;
    else if (sel_uni)   in_ready = !sel_full;
    else if (sel_bcast) in_ready = !(|full);  // broadcast is all-or-nothing
  end

  assign accept = bus.io_in_valid && in_ready;

  always_comb begin
    push = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      push[c] = accept && (sel_bcast || (sel_uni && bus.io_OPR_sel == SEL_W'(c)));
    end
  end

  // Pops offered during a flush are ignored; the flush empties everything.
  assign pop = bus.io_flush ? '0 : (not_empty & bus.io_out_ready);

  // NOTE: storage has no reset; occupancy gates the output to zero, so the
  // contents are never observable before being written.
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= bus.io_operand;
    end
  end

  // NOTE: registered state uses non-blocking assignments only, so every
  // process sees pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        rd_ptr_q[c] <= '0;
        wr_ptr_q[c] <= '0;
        occ_q[c]    <= '0;
      end
      drop_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.io_flush) begin
          rd_ptr_q[c] <= '0;
          wr_ptr_q[c] <= '0;
          occ_q[c]    <= '0;
        end else begin
          if (push[c]) wr_ptr_q[c] <= (wr_ptr_q[c] == PTR_LAST) ? '0 : wr_ptr_q[c] + 1'b1;
          if (pop[c])  rd_ptr_q[c] <= (rd_ptr_q[c] == PTR_LAST) ? '0 : rd_ptr_q[c] + 1'b1;
          case ({push[c], pop[c]})
            2'b10:   occ_q[c] <= occ_q[c] + 1'b1;
            2'b01:   occ_q[c] <= occ_q[c] - 1'b1;
            default: occ_q[c] <= occ_q[c];
          endcase
        end
      end
      if (accept && !sel_uni && !sel_bcast && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  assign bus.io_in_ready    = in_ready;
  assign bus.io_out_valid   = not_empty;
  assign bus.io_out_operand = out_operand;
  assign bus.io_drop_count  = drop_q;

endmodule

// File: tb/tb_opr_demux_buffered.sv
// Directed bench for opr_demux_buffered (WIDTH 8, 4 channels, DEPTH 2,
// 2-bit drop counter). A vector table covers unicast, back-pressure,
// broadcast, drop saturation and flush; hand sequences cover flush with a
// concurrent push and asynchronous reset between edges.
module tb_opr_demux_buffered;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 3;
  localparam int DEPTH    = 2;
  localparam int CNT_W    = 2;

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  op;
    logic        vld;
    logic [3:0]  ordy;
    logic        fl;
    logic        exp_rdy;    // io_in_ready before the edge
    logic [3:0]  exp_valid;  // after the edge
    logic [31:0] exp_data;   // after the edge, {ch3,ch2,ch1,ch0}
    logic [1:0]  exp_drop;   // after the edge
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  opr_demux_buffered_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

  opr_demux_buffered #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] sel, input logic [7:0] op, input logic vld,
                              input logic [3:0] ordy, input logic fl, input logic exp_rdy,
                              input logic [3:0] exp_valid, input logic [31:0] exp_data,
                              input logic [1:0] exp_drop);
    vec_t v;
    v.sel = sel; v.op = op; v.vld = vld; v.ordy = ordy; v.fl = fl;
    v.exp_rdy = exp_rdy; v.exp_valid = exp_valid; v.exp_data = exp_data; v.exp_drop = exp_drop;
    return v;
  endfunction

  task automatic push(input logic [2:0] sel, input logic [7:0] op);
    bus.io_OPR_sel  = sel;
    bus.io_operand  = op;
    bus.io_in_valid = 1'b1;
    step();
    bus.io_in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //            sel   op     vld ordy     fl  rdy valid    data          drop
    // unicast to ch2, then drain it
    vecs.push_back(mk(3'd2, 8'h06, 1, 4'b0000, 0, 1, 4'b0100, 32'h0006_0000, 2'd0));
    vecs.push_back(mk(3'd2, 8'h00, 0, 4'b0100, 0, 1, 4'b0000, 32'h0000_0000, 2'd0));
    // fill ch1, back-pressure, pop-while-full blocks push
    vecs.push_back(mk(3'd1, 8'h11, 1, 4'b0000, 0, 1, 4'b0010, 32'h0000_1100, 2'd0));
    vecs.push_back(mk(3'd1, 8'h22, 1, 4'b0000, 0, 1, 4'b0010, 32'h0000_1100, 2'd0));
    vecs.push_back(mk(3'd1, 8'h33, 1, 4'b0000, 0, 0, 4'b0010, 32'h0000_1100, 2'd0));
    vecs.push_back(mk(3'd0, 8'h44, 0, 4'b0000, 0, 1, 4'b0010, 32'h0000_1100, 2'd0));
    vecs.push_back(mk(3'd1, 8'h33, 1, 4'b0010, 0, 0, 4'b0010, 32'h0000_2200, 2'd0));
    vecs.push_back(mk(3'd1, 8'h00, 0, 4'b0010, 0, 1, 4'b0000, 32'h0000_0000, 2'd0));
    vecs.push_back(mk(3'd1, 8'h00, 0, 4'b0010, 0, 1, 4'b0000, 32'h0000_0000, 2'd0));
    // fill ch3, broadcast blocked until ch3 has room
    vecs.push_back(mk(3'd3, 8'h31, 1, 4'b0000, 0, 1, 4'b1000, 32'h3100_0000, 2'd0));
    vecs.push_back(mk(3'd3, 8'h32, 1, 4'b0000, 0, 1, 4'b1000, 32'h3100_0000, 2'd0));
    vecs.push_back(mk(3'd7, 8'hA5, 1, 4'b0000, 0, 0, 4'b1000, 32'h3100_0000, 2'd0));
    vecs.push_back(mk(3'd7, 8'hA5, 1, 4'b1000, 0, 0, 4'b1000, 32'h3200_0000, 2'd0));
    vecs.push_back(mk(3'd7, 8'hA5, 1, 4'b1000, 0, 1, 4'b1111, 32'hA5A5_A5A5, 2'd0));
    vecs.push_back(mk(3'd0, 8'h00, 0, 4'b1111, 0, 1, 4'b0000, 32'h0000_0000, 2'd0));
    // invalid select: absorbed, counter saturates at 3
    vecs.push_back(mk(3'd5, 8'hFF, 1, 4'b0000, 0, 1, 4'b0000, 32'h0000_0000, 2'd1));
    vecs.push_back(mk(3'd5, 8'hFF, 1, 4'b0000, 0, 1, 4'b0000, 32'h0000_0000, 2'd2));
    vecs.push_back(mk(3'd5, 8'hFF, 1, 4'b0000, 0, 1, 4'b0000, 32'h0000_0000, 2'd3));
    vecs.push_back(mk(3'd5, 8'hFF, 1, 4'b0000, 0, 1, 4'b0000, 32'h0000_0000, 2'd3));
    vecs.push_back(mk(3'd5, 8'hFF, 1, 4'b0000, 0, 1, 4'b0000, 32'h0000_0000, 2'd3));
    // flush leaves the drop count alone
    vecs.push_back(mk(3'd6, 8'h00, 0, 4'b0000, 1, 0, 4'b0000, 32'h0000_0000, 2'd3));

    reset            = 1'b0;
    bus.io_flush     = 1'b0;
    bus.io_in_valid  = 1'b0;
    bus.io_operand   = '0;
    bus.io_OPR_sel   = '0;
    bus.io_out_ready = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;

    check("reset_valid", 64'(bus.io_out_valid), 64'h0);
    check("reset_data",  64'(bus.io_out_operand), 64'h0);
    check("reset_drop",  64'(bus.io_drop_count), 64'h0);
    for (int s = 0; s < 8; s++) begin
      bus.io_OPR_sel = 3'(s);
      #1;
      check($sformatf("reset_ready_sel%0d", s), 64'(bus.io_in_ready), 64'h1);
    end
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      bus.io_OPR_sel   = vecs[i].sel;
      bus.io_operand   = vecs[i].op;
      bus.io_in_valid  = vecs[i].vld;
      bus.io_out_ready = vecs[i].ordy;
      bus.io_flush     = vecs[i].fl;
      #1;
      check($sformatf("v%0d_in_ready", i), 64'(bus.io_in_ready), 64'(vecs[i].exp_rdy));
      step();
      check($sformatf("v%0d_out_valid", i), 64'(bus.io_out_valid), 64'(vecs[i].exp_valid));
      check($sformatf("v%0d_out_data", i),  64'(bus.io_out_operand), 64'(vecs[i].exp_data));
      check($sformatf("v%0d_drop", i),      64'(bus.io_drop_count), 64'(vecs[i].exp_drop));
    end
    bus.io_in_valid  = 1'b0;
    bus.io_out_ready = '0;
    bus.io_flush     = 1'b0;

    // Flush with a concurrent push on ch0: push refused and lost.
    push(3'd0, 8'h01);
    push(3'd1, 8'h02);
    push(3'd2, 8'h03);
    check("pre_flush_valid", 64'(bus.io_out_valid), 64'h7);
    check("pre_flush_data",  64'(bus.io_out_operand), 64'h0003_0201);
    bus.io_flush    = 1'b1;
    bus.io_OPR_sel  = 3'd0;
    bus.io_operand  = 8'h0E;
    bus.io_in_valid = 1'b1;
    bus.io_out_ready = 4'b0001;
    #1;
    check("flush_in_ready", 64'(bus.io_in_ready), 64'h0);
    step();
    bus.io_flush     = 1'b0;
    bus.io_in_valid  = 1'b0;
    bus.io_out_ready = '0;
    check("flush_valid", 64'(bus.io_out_valid), 64'h0);
    check("flush_data",  64'(bus.io_out_operand), 64'h0);
    step();
    check("flush_push_lost", 64'(bus.io_out_valid), 64'h0);
    check("flush_drop_kept", 64'(bus.io_drop_count), 64'h3);

    // Refill, then reset between clock edges.
    push(3'd0, 8'h0A);
    push(3'd3, 8'h0B);
    check("refill_valid", 64'(bus.io_out_valid), 64'h9);
    check("refill_data",  64'(bus.io_out_operand), 64'h0B00_000A);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_valid", 64'(bus.io_out_valid), 64'h0);
    check("async_reset_data",  64'(bus.io_out_operand), 64'h0);
    check("async_reset_drop",  64'(bus.io_drop_count), 64'h0);
    step();
    reset = 1'b1;
    step();
    check("post_reset_valid", 64'(bus.io_out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
